spram_fifo_ctrl: RTL and testbench

//   Synchronous FIFO controller for a single-port SRAM. Drives one std_spram32x32 instance
//   (active-low CEB/WEB, 1-cycle read latency) and presents valid/ready push and pop

---
 rtl/spram_fifo_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_spram_fifo_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// spram_fifo_ctrl
//   Synchronous FIFO controller wrapped around a single-port SRAM with active-low
//   chip/write enables and a one-cycle read latency. The single RAM port is
//   shared between writes and reads. A two-entry registered output buffer hides
//   the read latency. While nothing older is queued, pushes go directly into
//   that buffer (bypass), which gives one word per cycle.
//
//   Optional feature macro: SPRAM_FIFO_STAT_EN. When it is defined, the block
//   adds the peak_count port, which holds the highest occupancy seen since the
//   last reset.
//
// Ports
//   clk         clock, also the RAM clock
//   rst         synchronous reset, active-high
//   in_valid    push request
//   in_ready    push accepted when in_valid && in_ready
//   in_data     push data
//   out_valid   head word available
//   out_ready   pop when out_valid && out_ready
//   out_data    head word (registered)
//   count       total words held (RAM + output buffer + read in flight)
//   ram_ceb     RAM chip enable, active-low
//   ram_web     RAM write enable, active-low (0 = write)
//   ram_a       RAM address
//   ram_d       RAM write data
//   ram_q       RAM read data, valid the cycle after a read
//   peak_count  maximum of count since reset (SPRAM_FIFO_STAT_EN only)
// -----------------------------------------------------------------------------
module spram_fifo_ctrl #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 5,
  parameter  int DEPTH      = 32,
  localparam int CNT_W      = ADDR_WIDTH + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      count,
  output logic                  ram_ceb,
  output logic                  ram_web,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
`ifdef SPRAM_FIFO_STAT_EN
  ,
  output logic [CNT_W-1:0]      peak_count
`endif
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wptr_r;
  logic [ADDR_WIDTH-1:0] rptr_r;
  logic [ADDR_WIDTH:0]   ram_cnt_r;
  logic                  rd_pend_r;
  logic [1:0]            buf_cnt_r;
  logic [DATA_WIDTH-1:0] buf0_r;      // oldest buffered word
  logic [DATA_WIDTH-1:0] buf1_r;
  logic [ADDR_WIDTH-1:0] last_a_r;    // address held on idle cycles
  logic [DATA_WIDTH-1:0] last_d_r;    // write data held on idle/read cycles

  logic                  rd_issue_s;
  logic                  bypass_ok_s;
  logic                  push_s;
  logic                  push_byp_s;
  logic                  push_ram_s;
  logic                  pop_s;
  logic                  buf_wr_s;
  logic [DATA_WIDTH-1:0] buf_wdata_s;

  // Port arbitration and handshake decode, derived from registered state only.
  always_comb begin
    // Keep the buffer plus the in-flight read at or below two words, so a
    // returning read always finds room.
    rd_issue_s  = (ram_cnt_r != '0) && ((buf_cnt_r + {1'b0, rd_pend_r}) < 2'd2);
    // Bypass only while nothing older sits in the RAM or in flight.
    bypass_ok_s = (ram_cnt_r == '0) && !rd_pend_r && (buf_cnt_r < 2'd2);
    in_ready    = !rst && !rd_issue_s && (bypass_ok_s || (ram_cnt_r < DEPTH_L));
    push_s      = in_valid && in_ready;
    push_byp_s  = push_s && bypass_ok_s;
    push_ram_s  = push_s && !bypass_ok_s;
    out_valid   = !rst && (buf_cnt_r != 2'd0);
    pop_s       = out_valid && out_ready;
    // A capture and a bypass write never coincide, because bypass needs !rd_pend.
    buf_wr_s    = rd_pend_r || push_byp_s;
    if (rd_pend_r) begin
      buf_wdata_s = ram_q;
    end else begin
      buf_wdata_s = in_data;
    end
  end

  // RAM port drive: a read has priority; a push is never accepted in a read cycle.
  always_comb begin
    if (rst) begin
      ram_ceb = 1'b1;
      ram_web = 1'b1;
      ram_a   = '0;
      ram_d   = '0;
    end else if (rd_issue_s) begin
      ram_ceb = 1'b0;
      ram_web = 1'b1;
      ram_a   = rptr_r;
      ram_d   = last_d_r;
    end else if (push_ram_s) begin
      ram_ceb = 1'b0;
      ram_web = 1'b0;
      ram_a   = wptr_r;
      ram_d   = in_data;
    end else begin
      ram_ceb = 1'b1;
      ram_web = 1'b1;
      ram_a   = last_a_r;
      ram_d   = last_d_r;
    end
  end

  // Occupancy and head-word outputs.
  always_comb begin
    if (rst) begin
      count = '0;
    end else begin
      count = CNT_W'(ram_cnt_r) + CNT_W'(buf_cnt_r) + CNT_W'(rd_pend_r);
    end
    out_data = buf0_r;
  end

  // RAM pointers, RAM occupancy, read-pending flag and held port values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r    <= '0;
      rptr_r    <= '0;
      ram_cnt_r <= '0;
      rd_pend_r <= 1'b0;
      last_a_r  <= '0;
      last_d_r  <= '0;
    end else begin
      if (rd_issue_s) begin
        rptr_r   <= rptr_r + PTR_ONE;
        last_a_r <= rptr_r;
      end else if (push_ram_s) begin
        wptr_r   <= wptr_r + PTR_ONE;
        last_a_r <= wptr_r;
        last_d_r <= in_data;
      end
      // A read and a RAM write are never issued in the same cycle.
      ram_cnt_r <= ram_cnt_r + {{ADDR_WIDTH{1'b0}}, push_ram_s}
                             - {{ADDR_WIDTH{1'b0}}, rd_issue_s};
      // A read issued now supersedes any capture that clears the flag this cycle.
      rd_pend_r <= rd_issue_s;
    end
  end

  // Two-entry output buffer: buf0 is the head; pops shift buf1 forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_cnt_r <= 2'd0;
      buf0_r    <= '0;
      buf1_r    <= '0;
    end else begin
      case ({pop_s, buf_wr_s})
        2'b01: begin
          if (buf_cnt_r == 2'd0) begin
            buf0_r <= buf_wdata_s;
          end else begin
            buf1_r <= buf_wdata_s;
          end
          buf_cnt_r <= buf_cnt_r + 2'd1;
        end
        2'b10: begin
          buf0_r    <= buf1_r;
          buf_cnt_r <= buf_cnt_r - 2'd1;
        end
        2'b11: begin
          if (buf_cnt_r == 2'd1) begin
            buf0_r <= buf_wdata_s;
          end else begin
            buf0_r <= buf1_r;
            buf1_r <= buf_wdata_s;
          end
        end
        default: begin
          buf_cnt_r <= buf_cnt_r;
        end
      endcase
    end
  end

`ifdef SPRAM_FIFO_STAT_EN
  logic [CNT_W-1:0] peak_r;

  // High-water mark of count; lags count by one cycle and never decreases.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_r <= '0;
    end else if (count > peak_r) begin
      peak_r <= count;
    end
  end

  assign peak_count = peak_r;
`endif

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spram_fifo_ctrl
//   Directed and randomized bench for spram_fifo_ctrl. It contains a
//   behavioural single-port RAM and a queue-based reference that holds every
//   accepted and not yet popped word.
// -----------------------------------------------------------------------------
module tb_spram_fifo_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [6:0]  count;
  logic        ram_ceb;
  logic        ram_web;
  logic [4:0]  ram_a;
  logic [31:0] ram_d;
  logic [31:0] ram_q;
`ifdef SPRAM_FIFO_STAT_EN
  logic [6:0]  peak_count;
`endif

  spram_fifo_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count),
    .ram_ceb    (ram_ceb),
    .ram_web    (ram_web),
    .ram_a      (ram_a),
    .ram_d      (ram_d),
    .ram_q      (ram_q)
`ifdef SPRAM_FIFO_STAT_EN
    ,
    .peak_count (peak_count)
`endif
  );

  // Behavioural 32x32 single-port RAM, active-low enables, 1-cycle read latency.
  logic [31:0] mem [0:31];
  always @(posedge clk) begin
    if (!ram_ceb) begin
      if (!ram_web) begin
        mem[ram_a] <= ram_d;
      end else begin
        ram_q <= mem[ram_a];
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  logic [31:0] q[$];        // reference contents, head at index 0
  logic        last_push;
  logic        saw_read;
  logic        ceb_low_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after negedge, check before posedge, and
  // advance the reference model on accepted pushes and pops.
  task automatic cycle(input logic iv, input logic [31:0] id, input logic ordy);
    logic push;
    logic pop;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #2;
    last_push = 1'b0;
    saw_read  = 1'b0;
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_ceb", ram_ceb, 1);
      chk("rst_web", ram_web, 1);
      chk("rst_a", ram_a, 0);
      chk("rst_d", ram_d, 0);
      chk("rst_count", count, 0);
      q.delete();
    end else begin
      chk("count", count, q.size());
      if (q.size() == 0) begin
        chk("empty_out_valid", out_valid, 0);
        chk("empty_in_ready", in_ready, 1);
      end
      if (q.size() == 34) chk("full_in_ready", in_ready, 0);
      if (out_valid) chk("head_data", out_data, q[0]);
      if (!ram_ceb) ceb_low_seen = 1'b1;
      if (!ram_ceb && !ram_web) begin
        chk("wr_with_push", in_valid && in_ready, 1);
        chk("wr_data", ram_d, in_data);
      end
      if (!ram_ceb && ram_web) begin
        saw_read = 1'b1;
        chk("rd_no_push", in_ready, 0);
        chk("rd_nonempty", q.size() != 0, 1);
      end
      push = iv && in_ready;
      pop  = out_valid && ordy;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(id);
      last_push = push;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int          acc;
    int          next_exp;
    int          budget;
    logic        iv;
    logic        ordy;
    checks       = 0;
    errors       = 0;
    ceb_low_seen = 1'b0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = 32'h0;
    out_ready    = 1'b0;
    @(negedge clk);

    // Scenario 1: reset, then one bypass push.
    cycle(1'b1, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    rst = 1'b0;
`ifdef SPRAM_FIFO_STAT_EN
    chk("peak_after_rst", peak_count, 0);
`endif
    ceb_low_seen = 1'b0;
    cycle(1'b1, 32'hA5A50001, 1'b1);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 32'hA5A50001);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t1_no_ram", ceb_low_seen, 0);
    chk("t1_count", count, 0);

    // Scenario 2: fill until full, with out_ready held low.
    acc = 0;
    for (int i = 0; i <= 40; i++) begin
      cycle(1'b1, 32'(i), 1'b0);
      if (last_push) acc++;
    end
    chk("t2_accepted", acc, 34);
    chk("t2_count", count, 34);
    chk("t2_in_ready", in_ready, 0);
    chk("t2_head", out_data, 0);
    for (int k = 0; k < 32; k++) chk("t2_ram_word", mem[k], 32'(k + 2));
`ifdef SPRAM_FIFO_STAT_EN
    chk("t2_peak", peak_count, 34);
`endif

    // Scenario 3: drain in order.
    next_exp = 0;
    budget   = 0;
    while (q.size() != 0 && budget < 200) begin
      if (out_valid) begin
        chk("t3_seq", out_data, 32'(next_exp));
        next_exp++;
      end
      cycle(1'b0, 32'h0, 1'b1);
      budget++;
    end
    chk("t3_drain_budget", budget < 200, 1);
    chk("t3_popped", next_exp, 34);
    chk("t3_count", count, 0);
    ceb_low_seen = 1'b0;
    for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 1'b1);
    chk("t3_idle_ram", ceb_low_seen, 0);
    chk("t3_out_valid", out_valid, 0);
`ifdef SPRAM_FIFO_STAT_EN
    chk("t3_peak", peak_count, 34);
`endif

    // Scenario 4: random traffic, first fill-biased, then drain-biased.
    for (int n = 0; n < 200; n++) begin
      if (n < 100) begin
        iv   = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 3) == 0);
      end else begin
        iv   = $urandom_range(0, 1) == 1;
        ordy = ($urandom_range(0, 3) != 0);
      end
      cycle(iv, $urandom, ordy);
    end
    budget = 0;
    while (q.size() != 0 && budget < 200) begin
      cycle(1'b0, 32'h0, 1'b1);
      budget++;
    end
    chk("t4_drain_budget", budget < 200, 1);
    chk("t4_count", count, 0);

    // Scenario 5: reset while a RAM read is in flight.
    rst = 1'b1;
    cycle(1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'(100 + i), 1'b0);
    budget = 0;
    cycle(1'b0, 32'h0, 1'b1);
    while (!saw_read && budget < 20) begin
      cycle(1'b0, 32'h0, 1'b1);
      budget++;
    end
    chk("t5_read_seen", saw_read, 1);
    rst = 1'b1;
    cycle(1'b0, 32'h0, 1'b1);
    rst = 1'b0;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_count", count, 0);
`ifdef SPRAM_FIFO_STAT_EN
    chk("t5_peak", peak_count, 0);
`endif
    for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'h1, 1'b0);
    chk("t5_fresh_valid", out_valid, 1);
    chk("t5_fresh_data", out_data, 32'h1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t5_final_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
